// File: rtl/rast_feed_pkg.sv
// Shared types, constants and the MSAA decode for the rasterizer triangle feeder.
package rast_feed_pkg;

  localparam int unsigned SIGFIG = 24;
  localparam int unsigned RADIX  = 10;
  localparam int unsigned AXIS   = 3;
  localparam int unsigned COLORS = 3;

  typedef logic [AXIS-1:0][SIGFIG-1:0]   vert_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0] color_t;

  // One queued primitive: a triangle uses verts[0..2], a quad uses all four.
  typedef struct packed {
    logic        quad;
    vert_t [3:0] verts;
    color_t      color;
  } tri_entry_t;

  typedef enum logic {
    EMIT0 = 1'b0,
    EMIT1 = 1'b1
  } emit_state_e;

  typedef struct packed {
    logic [3:0] sub_sample;
    logic [1:0] ss_w_lg2;
  } msaa_cfg_t;

  // 1x/4x/16x/64x MSAA maps to a one-hot sub-sample mask and sample-grid width.
  function automatic msaa_cfg_t msaa_decode(input logic [1:0] lg4);
    msaa_cfg_t c;
    c.sub_sample = 4'b1000 >> lg4;
    c.ss_w_lg2   = lg4;
    return c;
  endfunction

  // 512.0 in fixed point with RADIX fraction bits.
  localparam logic [SIGFIG-1:0] SCREEN_RST = SIGFIG'(32'd512 << RADIX);

endpackage

// File: rtl/rast_tri_fifo.sv
// Parametrised synchronous FIFO with registered occupancy count.
module rast_tri_fifo
  import rast_feed_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = tri_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  entry_t                   wdata,
  input  logic                     pop,
  output entry_t                   head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;
  assign head_c  = mem[rd_ptr];

  // Pointers wrap naturally; count carries the extra bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rast_tri_feeder.sv
// Triangle/quad queue feeding the rasterizer R10 interface, plus screen/MSAA config.
module rast_tri_feeder
  import rast_feed_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid_R9H,
  output logic                                in_ready_R9H,
  input  logic                                in_quad_R9H,
  input  logic [3:0][AXIS-1:0][SIGFIG-1:0]    in_tri_R9S,
  input  logic [COLORS-1:0][SIGFIG-1:0]       in_color_R9U,
  input  logic                                cfg_we,
  input  logic [1:0][SIGFIG-1:0]              cfg_screen,
  input  logic [1:0]                          cfg_msaa_lg4,
  output logic                                cfg_rej,
  input  logic                                halt_RnnnnL,
  output logic                                validTri_R10H,
  output logic [2:0][AXIS-1:0][SIGFIG-1:0]    tri_R10S,
  output logic [COLORS-1:0][SIGFIG-1:0]       color_R10U,
  output logic [1:0][SIGFIG-1:0]              screen_RnnnnS,
  output logic [3:0]                          subSample_RnnnnU,
  output logic [1:0]                          ss_w_lg2_RnnnnS,
  output logic                                idle
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  tri_entry_t                       wr_entry;
  tri_entry_t                       head;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic [CW-1:0]                    fifo_count;
  logic [CW-1:0]                    count_d;
  logic                             push_c;
  logic                             pop_c;
  logic                             load_en_c;
  emit_state_e                      state_q;
  emit_state_e                      state_d;
  logic                             valid_d;
  logic [2:0][AXIS-1:0][SIGFIG-1:0] tri_d;
  color_t                           color_d;
  msaa_cfg_t                        msaa_c;

  assign wr_entry = '{quad: in_quad_R9H, verts: in_tri_R9S, color: in_color_R9U};
  assign push_c   = in_valid_R9H && in_ready_R9H && !fifo_full;
  assign count_d  = fifo_count + CW'(push_c) - CW'(pop_c);
  assign msaa_c   = msaa_decode(cfg_msaa_lg4);

  rast_tri_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (tri_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .wdata   (wr_entry),
    .pop     (pop_c),
    .head_c  (head),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count   (fifo_count)
  );

  // EMIT1 means the output register holds the first half of the quad at the head.
  always_comb begin
    state_d   = state_q;
    valid_d   = validTri_R10H;
    tri_d     = tri_R10S;
    color_d   = color_R10U;
    pop_c     = 1'b0;
    load_en_c = !validTri_R10H || halt_RnnnnL;
    if (load_en_c) begin
      case (state_q)
        EMIT0: begin
          if (!fifo_empty) begin
            valid_d = 1'b1;
            tri_d   = {head.verts[2], head.verts[1], head.verts[0]};
            color_d = head.color;
            if (head.quad) state_d = EMIT1;
            else           pop_c   = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end
        EMIT1: begin
          valid_d = 1'b1;
          tri_d   = {head.verts[3], head.verts[2], head.verts[0]};
          color_d = head.color;
          pop_c   = 1'b1;
          state_d = EMIT0;
        end
        default: state_d = EMIT0;
      endcase
    end
  end

  // Output register, ready and idle all derive from next-cycle occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= EMIT0;
      validTri_R10H <= 1'b0;
      tri_R10S      <= '0;
      color_R10U    <= '0;
      in_ready_R9H  <= 1'b1;
      idle          <= 1'b1;
    end else begin
      state_q       <= state_d;
      validTri_R10H <= valid_d;
      tri_R10S      <= tri_d;
      color_R10U    <= color_d;
      in_ready_R9H  <= (count_d != CW'(DEPTH));
      idle          <= (count_d == '0) && !valid_d && (state_d == EMIT0);
    end
  end

  // Config only changes while nothing is in flight; otherwise the write is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      screen_RnnnnS    <= {SCREEN_RST, SCREEN_RST};
      subSample_RnnnnU <= 4'b0100;
      ss_w_lg2_RnnnnS  <= 2'd1;
      cfg_rej          <= 1'b0;
    end else begin
      cfg_rej <= cfg_we && !idle;
      if (cfg_we && idle) begin
        screen_RnnnnS    <= cfg_screen;
        subSample_RnnnnU <= msaa_c.sub_sample;
        ss_w_lg2_RnnnnS  <= msaa_c.ss_w_lg2;
      end
    end
  end

endmodule

// File: tb/tb_rast_tri_feeder.sv
// Self-checking bench for rast_tri_feeder: directed sequences plus scoreboarded random stress.
module tb_rast_tri_feeder;
  import rast_feed_pkg::*;

  localparam int unsigned DEPTH = 4;

  typedef logic [3:0][AXIS-1:0][SIGFIG-1:0] quad_v_t;
  typedef logic [2:0][AXIS-1:0][SIGFIG-1:0] tri_v_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0]    col_t;
  typedef logic [319:0]                     wide_t;

  typedef struct {
    logic [1:0]              lg4;
    logic [1:0][SIGFIG-1:0]  scr;
    logic [3:0]              sub;
    logic [1:0]              w;
  } cfg_vec_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid_R9H;
  logic                   in_ready_R9H;
  logic                   in_quad_R9H;
  quad_v_t                in_tri_R9S;
  col_t                   in_color_R9U;
  logic                   cfg_we;
  logic [1:0][SIGFIG-1:0] cfg_screen;
  logic [1:0]             cfg_msaa_lg4;
  logic                   cfg_rej;
  logic                   halt_RnnnnL;
  logic                   validTri_R10H;
  tri_v_t                 tri_R10S;
  col_t                   color_R10U;
  logic [1:0][SIGFIG-1:0] screen_RnnnnS;
  logic [3:0]             subSample_RnnnnU;
  logic [1:0]             ss_w_lg2_RnnnnS;
  logic                   idle;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rast_tri_feeder #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid_R9H     (in_valid_R9H),
    .in_ready_R9H     (in_ready_R9H),
    .in_quad_R9H      (in_quad_R9H),
    .in_tri_R9S       (in_tri_R9S),
    .in_color_R9U     (in_color_R9U),
    .cfg_we           (cfg_we),
    .cfg_screen       (cfg_screen),
    .cfg_msaa_lg4     (cfg_msaa_lg4),
    .cfg_rej          (cfg_rej),
    .halt_RnnnnL      (halt_RnnnnL),
    .validTri_R10H    (validTri_R10H),
    .tri_R10S         (tri_R10S),
    .color_R10U       (color_R10U),
    .screen_RnnnnS    (screen_RnnnnS),
    .subSample_RnnnnU (subSample_RnnnnU),
    .ss_w_lg2_RnnnnS  (ss_w_lg2_RnnnnS),
    .idle             (idle)
  );

  task automatic check(input string name, input wide_t act, input wide_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic quad_v_t mkq(input int base);
    quad_v_t q;
    for (int i = 0; i < 4; i++)
      for (int a = 0; a < 3; a++)
        q[i][a] = 24'(base + 3 * i + a);
    return q;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (!idle && n < 20) begin
      step();
      n++;
    end
    check(name, wide_t'(idle), 1);
  endtask

  cfg_vec_t   cv [5];
  quad_v_t    q;
  col_t       c;
  tri_v_t     et;
  wide_t      exp_q [$];
  wide_t      sb [$];
  int         acc;
  int         seen;
  int         sent;
  int         ntri;
  int         nquad;
  int         outs;

  initial begin
    rst          = 1'b1;
    in_valid_R9H = 1'b0;
    in_quad_R9H  = 1'b0;
    in_tri_R9S   = '0;
    in_color_R9U = '0;
    cfg_we       = 1'b0;
    cfg_screen   = '0;
    cfg_msaa_lg4 = 2'd0;
    halt_RnnnnL  = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_valid",  wide_t'(validTri_R10H), 0);
    check("rst_ready",  wide_t'(in_ready_R9H), 1);
    check("rst_rej",    wide_t'(cfg_rej), 0);
    check("rst_idle",   wide_t'(idle), 1);
    check("rst_screen", wide_t'(screen_RnnnnS), wide_t'({24'h080000, 24'h080000}));
    check("rst_sub",    wide_t'(subSample_RnnnnU), 4'b0100);
    check("rst_w",      wide_t'(ss_w_lg2_RnnnnS), 1);
    check("rst_tri",    wide_t'(tri_R10S), 0);
    check("rst_color",  wide_t'(color_R10U), 0);

    // Config decode table, all while idle; last entry leaves 16x and 256.0
    cv[0] = '{2'd0, {24'h0C8000, 24'h0A0000}, 4'b1000, 2'd0};
    cv[1] = '{2'd3, {24'h010000, 24'h020000}, 4'b0001, 2'd3};
    cv[2] = '{2'd1, {24'h123400, 24'h000400}, 4'b0100, 2'd1};
    cv[3] = '{2'd0, {24'h000000, 24'hFFFC00}, 4'b1000, 2'd0};
    cv[4] = '{2'd2, {24'h040000, 24'h040000}, 4'b0010, 2'd2};
    for (int i = 0; i < 5; i++) begin
      cfg_we       = 1'b1;
      cfg_msaa_lg4 = cv[i].lg4;
      cfg_screen   = cv[i].scr;
      step();
      cfg_we = 1'b0;
      check("cfg_sub",    wide_t'(subSample_RnnnnU), wide_t'(cv[i].sub));
      check("cfg_w",      wide_t'(ss_w_lg2_RnnnnS), wide_t'(cv[i].w));
      check("cfg_screen", wide_t'(screen_RnnnnS), wide_t'(cv[i].scr));
      check("cfg_norej",  wide_t'(cfg_rej), 0);
      step();
    end

    // Single triangle latency and one-cycle valid
    q = mkq(1);
    c = '0;
    c[0] = 24'hFF;
    et = {q[2], q[1], q[0]};
    halt_RnnnnL  = 1'b1;
    in_valid_R9H = 1'b1;
    in_quad_R9H  = 1'b0;
    in_tri_R9S   = q;
    in_color_R9U = c;
    step();
    in_valid_R9H = 1'b0;
    check("lat_early", wide_t'(validTri_R10H), 0);
    step();
    check("lat_valid", wide_t'(validTri_R10H), 1);
    check("lat_tri",   wide_t'(tri_R10S), wide_t'(et));
    check("lat_v0x",   wide_t'(tri_R10S[0][0]), 1);
    check("lat_v2z",   wide_t'(tri_R10S[2][2]), 9);
    check("lat_color", wide_t'(color_R10U), 24'hFF);
    step();
    check("lat_drop",  wide_t'(validTri_R10H), 0);
    check("lat_idle",  wide_t'(idle), 1);

    // Config write while busy is rejected
    halt_RnnnnL  = 1'b0;
    in_valid_R9H = 1'b1;
    step();
    in_valid_R9H = 1'b0;
    cfg_we       = 1'b1;
    cfg_msaa_lg4 = 2'd0;
    cfg_screen   = {24'h011000, 24'h022000};
    step();
    cfg_we = 1'b0;
    check("rej_pulse",  wide_t'(cfg_rej), 1);
    check("rej_sub",    wide_t'(subSample_RnnnnU), 4'b0010);
    check("rej_w",      wide_t'(ss_w_lg2_RnnnnS), 2);
    check("rej_screen", wide_t'(screen_RnnnnS), wide_t'({24'h040000, 24'h040000}));
    step();
    check("rej_end",    wide_t'(cfg_rej), 0);
    halt_RnnnnL = 1'b1;
    wait_idle("rej_drain");

    // Quad split into two triangles sharing colour
    q = '0;
    q[1][0] = 24'h400;
    q[2][0] = 24'h400;
    q[2][1] = 24'h400;
    q[3][1] = 24'h400;
    c = {24'h000003, 24'h000002, 24'h000001};
    in_valid_R9H = 1'b1;
    in_quad_R9H  = 1'b1;
    in_tri_R9S   = q;
    in_color_R9U = c;
    step();
    in_valid_R9H = 1'b0;
    step();
    check("quad_a_valid", wide_t'(validTri_R10H), 1);
    check("quad_a_tri",   wide_t'(tri_R10S), wide_t'({q[2], q[1], q[0]}));
    check("quad_a_color", wide_t'(color_R10U), wide_t'(c));
    step();
    check("quad_b_valid", wide_t'(validTri_R10H), 1);
    check("quad_b_tri",   wide_t'(tri_R10S), wide_t'({q[3], q[2], q[0]}));
    check("quad_b_v1y",   wide_t'(tri_R10S[1][1]), 24'h400);
    check("quad_b_color", wide_t'(color_R10U), wide_t'(c));
    step();
    check("quad_end", wide_t'(validTri_R10H), 0);
    check("quad_idle", wide_t'(idle), 1);

    // Fill under backpressure: DEPTH queued plus one in the output register
    halt_RnnnnL = 1'b0;
    in_quad_R9H = 1'b0;
    acc = 0;
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      if (!in_ready_R9H) break;
      q = mkq(100 + acc * 16);
      c = '0;
      c[0] = 24'(acc + 1);
      in_valid_R9H = 1'b1;
      in_tri_R9S   = q;
      in_color_R9U = c;
      exp_q.push_back(wide_t'({c, q[2], q[1], q[0]}));
      acc++;
      step();
    end
    in_valid_R9H = 1'b0;
    check("full_accepts", acc, DEPTH + 1);
    check("full_ready",   wide_t'(in_ready_R9H), 0);
    check("hold_valid",   wide_t'(validTri_R10H), 1);
    check("hold_data",    wide_t'({color_R10U, tri_R10S}), exp_q[0]);
    step();
    step();
    check("hold_data2",   wide_t'({color_R10U, tri_R10S}), exp_q[0]);
    halt_RnnnnL = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
      if (validTri_R10H) check("drain_order", wide_t'({color_R10U, tri_R10S}), exp_q.pop_front());
      step();
      if (n == 0) check("free_next", wide_t'(in_ready_R9H), 1);
    end
    check("drain_left", exp_q.size(), 0);
    wait_idle("drain_idle");

    // Reset while the first half of a quad is on the output
    halt_RnnnnL  = 1'b0;
    in_valid_R9H = 1'b1;
    in_quad_R9H  = 1'b1;
    in_tri_R9S   = mkq(500);
    step();
    in_valid_R9H = 1'b0;
    step();
    check("e1_valid", wide_t'(validTri_R10H), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_valid",  wide_t'(validTri_R10H), 0);
    check("rst2_idle",   wide_t'(idle), 1);
    check("rst2_sub",    wide_t'(subSample_RnnnnU), 4'b0100);
    check("rst2_w",      wide_t'(ss_w_lg2_RnnnnS), 1);
    check("rst2_screen", wide_t'(screen_RnnnnS), wide_t'({24'h080000, 24'h080000}));
    halt_RnnnnL = 1'b1;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      if (validTri_R10H) seen++;
      step();
    end
    check("rst2_nohalf", seen, 0);

    // Random stress against a scoreboard of expected triangles
    sent = 0;
    ntri = 0;
    nquad = 0;
    outs = 0;
    sb.delete();
    for (int cyc = 0; cyc < 20000 && (sent < 1000 || sb.size() > 0); cyc++) begin
      in_valid_R9H = (sent < 1000) && ($urandom_range(3) != 0);
      in_quad_R9H  = 1'($urandom_range(1));
      for (int i = 0; i < 4; i++)
        for (int a = 0; a < 3; a++)
          q[i][a] = 24'($urandom);
      for (int ch = 0; ch < 3; ch++) c[ch] = 24'($urandom);
      in_tri_R9S   = q;
      in_color_R9U = c;
      halt_RnnnnL  = ($urandom_range(2) != 0);
      if (in_valid_R9H && in_ready_R9H) begin
        sb.push_back(wide_t'({c, q[2], q[1], q[0]}));
        if (in_quad_R9H) begin
          sb.push_back(wide_t'({c, q[3], q[2], q[0]}));
          nquad++;
        end else begin
          ntri++;
        end
        sent++;
      end
      if (validTri_R10H && halt_RnnnnL) begin
        outs++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rand_extra: unexpected output %0h", {color_R10U, tri_R10S});
        end else begin
          check("rand_tri", wide_t'({color_R10U, tri_R10S}), sb.pop_front());
        end
      end
      step();
    end
    in_valid_R9H = 1'b0;
    check("rand_left",  sb.size(), 0);
    check("rand_sent",  sent, 1000);
    check("rand_count", outs, ntri + 2 * nquad);
    wait_idle("rand_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rast_tri_feeder.md
# rast_tri_feeder

Synthesizable triangle feeder at the rasterizer front end. It replaces file-driven stimulus with a hardware queue that accepts single triangles or quads, splits each quad into two triangles, and presents one triangle per transfer on the R10 interface under `halt_RnnnnL` backpressure. It also holds the screen and MSAA configuration and decodes it into the `subSample_RnnnnU` / `ss_w_lg2_RnnnnS` form the rasterizer consumes.

## Interface
- SIGFIG, 24, bits in colour and position
- RADIX, 10, fraction bits
- AXIS, 3, axes per vertex (x,y,z)
- COLORS, 3, colour channels
- DEPTH, 4, queue entries (power of two, ≥2)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid_R9H  in  1  upstream primitive valid
- in_ready_R9H  out  1  queue can accept
- in_quad_R9H  in  1  1 = 4 vertices, 0 = triangle (vertex 3 ignored)
- in_tri_R9S  in  [3:0][AXIS-1:0] × SIGFIG signed  vertices
- in_color_R9U  in  [COLORS-1:0] × SIGFIG  colour
- cfg_we  in  1  config write strobe
- cfg_screen  in  [1:0] × SIGFIG  width, height (fixed point)
- cfg_msaa_lg4  in  2  0→1x, 1→4x, 2→16x, 3→64x
- cfg_rej  out  1  one-cycle pulse: config write ignored
- halt_RnnnnL  in  1  1 = downstream accepts this cycle
- validTri_R10H  out  1  output triangle valid
- tri_R10S  out  [2:0][AXIS-1:0] × SIGFIG signed
- color_R10U  out  [COLORS-1:0] × SIGFIG
- screen_RnnnnS  out  [1:0] × SIGFIG signed
- subSample_RnnnnU  out  4
- ss_w_lg2_RnnnnS  out  2
- idle  out  1  queue empty, output invalid, state EMIT0

## Operation
- Queue entry = {quad flag, 4 vertices, colour}. Write on `in_valid_R9H && in_ready_R9H`.
- Output transfer = `validTri_R10H && halt_RnnnnL` at a rising edge.
- Emit FSM, states EMIT0 and EMIT1:
  - EMIT0: the output register loads the queue head as (v0,v1,v2).
  - A triangle entry pops on load.
  - A quad entry does not pop. On transfer of (v0,v1,v2) the FSM moves to EMIT1 and loads (v0,v2,v3), reusing the same colour. It pops on that load and returns to EMIT0.
- The output register loads whenever it is empty or transferring. Otherwise it holds all outputs stable.
- Config:
  - `cfg_we` is applied only when `idle`. Otherwise it is ignored and `cfg_rej` pulses.
  - Decode: 0→4'b1000/0, 1→4'b0100/1, 2→4'b0010/2, 3→4'b0001/3.
- Reset values:
  - validTri_R10H=0, in_ready_R9H=1 (first cycle after reset), cfg_rej=0, idle=1.
  - Queue empty, state EMIT0.
  - screen_RnnnnS[0]=screen_RnnnnS[1]={1'b1,19'd0} (512.0).
  - subSample_RnnnnU=4'b0100, ss_w_lg2_RnnnnS=1.
  - tri_R10S and color_R10U = 0.
- Reset mid-operation drops all queued and in-flight primitives, including the second half of a quad.

## Timing
- `in_ready_R9H` = queue not full. It is registered from the occupancy count; there is no combinational path from `halt_RnnnnL`.
- Latency: a triangle written at edge t into an empty queue with an empty output register shows `validTri_R10H`=1 after edge t+1.
- Throughput: one triangle per cycle while `halt_RnnnnL`=1. A quad takes 2 cycles.
- Full: with DEPTH entries, `in_ready_R9H`=0. A simultaneous pop frees the slot for the next cycle, not the same cycle.
- Empty: on a transfer with an empty queue, `validTri_R10H` drops to 0 the next cycle.
- Pointers are log2(DEPTH) bits with natural wrap. The count is log2(DEPTH)+1 bits.
- A config update is visible on the outputs one cycle after `cfg_we`.

## Structure
- Package `rast_feed_pkg` holds:
  - entry struct typedef;
  - emit-state enum;
  - MSAA decode function;
  - reset screen constant.
- Sub-module `rast_tri_fifo`: parametrised synchronous FIFO (DEPTH, entry type) with full/empty/count.

## Test plan
- Single triangle, `halt_RnnnnL`=1: verts (1,2,3),(4,5,6),(7,8,9), colour (0xFF,0,0) → `validTri_R10H` high exactly one cycle, 1 cycle after the write, matching data.
- Quad v0..v3 = (0,0),(0x400,0),(0x400,0x400),(0,0x400) → two consecutive triangles (v0,v1,v2) then (v0,v2,v3), both with the same colour, one pop.
- Hold `halt_RnnnnL`=0 while writing DEPTH+1 entries → `in_ready_R9H` drops after DEPTH+1 accepts (queue plus output register), outputs stay stable, no loss. Release → all drain in order.
- Config: `cfg_we` with msaa_lg4=2, screen 256.0 while idle → subSample 4'b0010, ss_w_lg2 2, screen 0x40000. Repeat while a triangle is queued → `cfg_rej` pulse, config unchanged.
- Assert `rst` during EMIT1 of a quad → next cycle validTri 0, idle 1, defaults restored; the second triangle is never emitted.
- Random valid/halt stress, 1000 mixed primitives, checked against a scoreboard → exact order and count, 1 output per triangle, 2 per quad.
